// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with one-word lines, zero-cycle hits
// and hit/miss counters. Ports: datapath side imemREN/imemaddr -> ihit/imemload;
// memory side iREN/iaddr <- iwait/iload; hit_count/miss_count for performance.
module icache_direct #(
  parameter int SETS  = 16,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  typedef enum logic {
    COMPARE = 1'b0,
    FETCH   = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [31:0]      fill_addr_q, fill_addr_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic [TW-1:0]    tag_arr [SETS];
  logic [31:0]      data_arr [SETS];

  logic [IW-1:0]    req_idx;
  logic [TW-1:0]    req_tag;
  logic [IW-1:0]    fill_idx;
  logic [TW-1:0]    fill_tag;
  logic             tag_eq;
  logic             fill_we;
  logic             unused_addr_bits;

  assign req_idx  = imemaddr[IW+1:2];
  assign req_tag  = imemaddr[31:IW+2];
  assign fill_idx = fill_addr_q[IW+1:2];
  assign fill_tag = fill_addr_q[31:IW+2];
  assign tag_eq   = (tag_arr[req_idx] == req_tag);

  // Byte offset never selects anything in a word-wide cache.
  assign unused_addr_bits = ^imemaddr[1:0];

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    fill_addr_d = fill_addr_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    ihit        = 1'b0;
    imemload    = 32'h0;
    iREN        = 1'b0;
    iaddr       = 32'h0;
    fill_we     = 1'b0;
    unique case (state_q)
      COMPARE: begin
        // imemREN gates first so an unknown address cannot leak out.
        ihit = imemREN & valid_q[req_idx] & tag_eq;
        if (ihit) begin
          imemload  = data_arr[req_idx];
          hit_cnt_d = hit_cnt_q + 1'b1;
        end else if (imemREN) begin
          fill_addr_d = {imemaddr[31:2], 2'b00};
          miss_cnt_d  = miss_cnt_q + 1'b1;
          state_d     = FETCH;
        end
      end
      FETCH: begin
        iREN  = 1'b1;
        iaddr = fill_addr_q;
        // The fill completes regardless of what the datapath does now.
        if (!iwait) begin
          fill_we           = 1'b1;
          valid_d[fill_idx] = 1'b1;
          state_d           = COMPARE;
        end
      end
      default: state_d = COMPARE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= COMPARE;
      valid_q     <= '0;
      fill_addr_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      fill_addr_q <= fill_addr_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  // Arrays carry no reset; the valid bits alone guard them.
  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_arr[fill_idx]  <= fill_tag;
      data_arr[fill_idx] <= iload;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: directed requests push expected hit data
// and fill addresses; a negedge monitor pops and compares as the DUT responds.
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'h0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload = 32'h0;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checks = 0;
  int errors = 0;
  int wait_n = 2;
  int mcnt = 0;
  int ren_run = 0;
  logic ren_prev = 1'b0;
  int exp_hits = 0;
  int exp_misses = 0;

  logic [31:0] exp_hit_q [$];
  logic [31:0] exp_fill_q [$];

  icache_direct #(.SETS(16), .CNT_W(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload),
    .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h00: return 32'h8C220004;
      32'h40: return 32'h24010040;
      32'h10: return 32'h20420010;
      32'h80: return 32'h3C01ABCD;
      default: return {16'hDEAD, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory controller model: wait_n busy cycles, then one data cycle.
  always @(negedge CLK) begin
    if (iREN && nRST) begin
      if (mcnt < wait_n) begin
        iwait = 1'b1;
        iload = 32'h0;
        mcnt++;
      end else begin
        iwait = 1'b0;
        iload = mem_word(iaddr);
        mcnt = 0;
      end
    end else begin
      iwait = 1'b1;
      iload = 32'h0;
      mcnt = 0;
    end
  end

  // Monitor
  always @(negedge CLK) begin
    if (nRST) begin
      if (ihit) begin
        if (exp_hit_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_hit: got data %h expected no hit", imemload);
        end else begin
          chk("imemload", imemload, exp_hit_q.pop_front());
        end
        chk("iren_during_hit", {31'h0, iREN}, 32'h0);
      end
      if (iREN && !ren_prev) begin
        if (exp_fill_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: got iaddr %h expected no fetch", iaddr);
        end else begin
          chk("iaddr", iaddr, exp_fill_q.pop_front());
        end
      end
      if (iREN) begin
        ren_run++;
      end else if (ren_prev) begin
        chk("fetch_len", ren_run, wait_n + 1);
        ren_run = 0;
      end
      ren_prev = iREN;
    end else begin
      ren_run = 0;
      ren_prev = 1'b0;
    end
  end

  task automatic req(input logic [31:0] a, input logic [31:0] d,
                     input bit miss);
    bit seen;
    @(posedge CLK);
    #1;
    imemREN = 1'b1;
    imemaddr = a;
    exp_hit_q.push_back(d);
    exp_hits++;
    if (miss) begin
      exp_fill_q.push_back({a[31:2], 2'b00});
      exp_misses++;
    end
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge CLK);
      seen = ihit;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL req_timeout: got no hit for %h expected hit", a);
      exp_hit_q.delete();
    end
  endtask

  task automatic drop();
    @(posedge CLK);
    #1;
    imemREN = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_hit_count"}, hit_count, exp_hits);
    chk({tag, "_miss_count"}, miss_count, exp_misses);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit done;
    // Reset state
    #12;
    chk("rst_ihit", {31'h0, ihit}, 32'h0);
    chk("rst_iren", {31'h0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_imemload", imemload, 32'h0);
    chk_cnt("rst");
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;

    // Cold miss
    wait_n = 2;
    req(32'h0, 32'h8C220004, 1'b1);
    drop();
    chk_cnt("cold");

    // Hits, back to back
    req(32'h0, 32'h8C220004, 1'b0);
    req(32'h3, 32'h8C220004, 1'b0);
    drop();
    chk_cnt("hit");

    // Conflict eviction at index 0
    req(32'h40, 32'h24010040, 1'b1);
    req(32'h0, 32'h8C220004, 1'b1);
    drop();
    chk_cnt("conflict");

    // Request withdrawn mid-fetch
    wait_n = 4;
    @(posedge CLK);
    #1;
    imemREN = 1'b1;
    imemaddr = 32'h10;
    exp_fill_q.push_back(32'h10);
    exp_misses++;
    repeat (2) @(posedge CLK);
    #1;
    imemREN = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      done = !iREN;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL withdraw_timeout: got iREN stuck expected fill done");
    end
    req(32'h10, 32'h20420010, 1'b0);
    drop();
    chk_cnt("withdraw");

    // Idle with random addresses
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      #1;
      imemaddr = $urandom;
      @(negedge CLK);
      chk("idle_ihit", {31'h0, ihit}, 32'h0);
      chk("idle_iren", {31'h0, iREN}, 32'h0);
      chk("idle_imemload", imemload, 32'h0);
    end
    chk_cnt("idle");

    // Reset during FETCH
    wait_n = 5;
    @(posedge CLK);
    #1;
    imemREN = 1'b1;
    imemaddr = 32'h80;
    exp_fill_q.push_back(32'h80);
    repeat (2) @(posedge CLK);
    #2;
    nRST = 1'b0;
    imemREN = 1'b0;
    #1;
    exp_hits = 0;
    exp_misses = 0;
    chk("rst_fetch_iren", {31'h0, iREN}, 32'h0);
    chk_cnt("rst_fetch");
    repeat (2) @(posedge CLK);
    #1;
    nRST = 1'b1;
    wait_n = 2;
    req(32'h0, 32'h8C220004, 1'b1);
    req(32'h10, 32'h20420010, 1'b1);
    drop();
    chk_cnt("post_rst");

    repeat (3) @(posedge CLK);
    chk("hit_q_left", exp_hit_q.size(), 32'h0);
    chk("fill_q_left", exp_fill_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
